mem_port_arbiter: RTL and testbench

- Shares the single synchronous data/instruction memory port between two requesters: the CPU fetch/load/store unit and a DMA/loader engine.
- Round-robin arbitration with a bounded grant-hold burst, so neither side can starve the other.
- Sits between the requesters and the RAM.
- Each requester must hold its command until it sees its grant; the arbiter then forwards the granted command/address/write-data and flags read-data validity one cycle later.

---
 rtl/mem_pkg.sv | 11 +
 rtl/arb_hold_counter.sv | 21 ++
 rtl/mem_port_arbiter.sv | 76 +++++++
 tb/tb_mem_port_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory command encodings and arbiter state type
package mem_pkg;
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILL   = 2'b11;
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA} arb_state_t;
  function automatic logic is_req(input logic [1:0] c);
    return c == MREAD || c == MWRITE;
  endfunction
endpackage

// File: rtl/arb_hold_counter.sv
// arb_hold_counter: saturating count of consecutive cycles in one grant
module arb_hold_counter #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_max
);
  localparam int W = $clog2(MAX_HOLD + 1);
  localparam logic [W-1:0] MAX = W'(MAX_HOLD);
  logic [W-1:0] cnt;
  // clear loads 1 because entering a grant already counts as its first cycle
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (clear) cnt <= W'(1);
    else if (enable && cnt != MAX) cnt <= cnt + 1'b1;
  end
  assign at_max = cnt == MAX;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between CPU and DMA
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_cmd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic [1:0]        dma_cmd,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cmd_err
);
  arb_state_t state, next_state;
  logic last_dma, at_max, cpu_req, dma_req, entering, unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign cpu_req = is_req(cpu_cmd);
  assign dma_req = is_req(dma_cmd);
  assign cpu_gnt = state == GNT_CPU;
  assign dma_gnt = state == GNT_DMA;
  assign entering = next_state != IDLE && next_state != state;
  // next grant: keep the owner until it stops or its burst expires under contention
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = cpu_req && dma_req ? (last_dma ? GNT_CPU : GNT_DMA) :
                            cpu_req ? GNT_CPU : dma_req ? GNT_DMA : IDLE;
      GNT_CPU: next_state = cpu_req && !(dma_req && at_max) ? GNT_CPU : dma_req ? GNT_DMA : IDLE;
      GNT_DMA: next_state = dma_req && !(cpu_req && at_max) ? GNT_DMA : cpu_req ? GNT_CPU : IDLE;
      default: next_state = IDLE;
    endcase
  end
  arb_hold_counter #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .clear  (entering),
    .enable (next_state == state && state != IDLE),
    .at_max (at_max)
  );
  // state, round-robin pointer, read-valid flags and sticky illegal-command flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_dma   <= 1'b1;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= next_state;
      if (entering) last_dma <= next_state == GNT_DMA;
      cpu_rvalid <= cpu_gnt && cpu_cmd == MREAD;
      dma_rvalid <= dma_gnt && dma_cmd == MREAD;
      if ((cpu_gnt && cpu_cmd == MILL) || (dma_gnt && dma_cmd == MILL)) cmd_err <= 1'b1;
    end
  end
  // forward the granted requester to RAM; an illegal command is squashed to NONE
  always_comb begin
    mem_cmd   = cpu_gnt ? (cpu_cmd == MILL ? MNONE : cpu_cmd) :
                dma_gnt ? (dma_cmd == MILL ? MNONE : dma_cmd) : MNONE;
    mem_addr  = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized check against an ownership model
module tb_mem_port_arbiter;
  localparam int MAX = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] cpu_cmd = 2'b00, dma_cmd = 2'b00, mem_cmd;
  logic [8:0] cpu_addr = '0, dma_addr = '0, mem_addr;
  logic [15:0] cpu_wdata = '0, dma_wdata = '0, mem_wdata, mem_rdata = '0;
  logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, cmd_err;
  int checks = 0, failures = 0;
  int own = 0, run = 0, last = 2;
  bit m_crv = 0, m_drv = 0, m_err = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dma_cmd(dma_cmd), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  // one clock: drive inputs, compare every output against the model, then advance the model
  task automatic cyc(input bit r, input logic [1:0] cc, input logic [8:0] ca, input logic [15:0] cw,
                     input logic [1:0] dc, input logic [8:0] da, input logic [15:0] dw);
    bit creq, dreq, mine, other;
    int nxt;
    logic [1:0] ecmd;
    @(posedge clk);
    #1;
    reset = r; cpu_cmd = cc; cpu_addr = ca; cpu_wdata = cw;
    dma_cmd = dc; dma_addr = da; dma_wdata = dw; mem_rdata = 16'($urandom);
    @(negedge clk);
    ecmd = own == 1 ? (cc == 2'b11 ? 2'b00 : cc) : own == 2 ? (dc == 2'b11 ? 2'b00 : dc) : 2'b00;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(own == 1));
    chk("dma_gnt", 32'(dma_gnt), 32'(own == 2));
    chk("mem_cmd", 32'(mem_cmd), 32'(ecmd));
    chk("mem_addr", 32'(mem_addr), own == 1 ? 32'(ca) : own == 2 ? 32'(da) : 0);
    chk("mem_wdata", 32'(mem_wdata), own == 1 ? 32'(cw) : own == 2 ? 32'(dw) : 0);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(m_drv));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
    if (r) begin
      own = 0; run = 0; last = 2; m_crv = 0; m_drv = 0; m_err = 0;
    end else begin
      creq = cc == 2'b01 || cc == 2'b10;
      dreq = dc == 2'b01 || dc == 2'b10;
      m_crv = own == 1 && cc == 2'b01;
      m_drv = own == 2 && dc == 2'b01;
      if ((own == 1 && cc == 2'b11) || (own == 2 && dc == 2'b11)) m_err = 1;
      if (own == 0) nxt = creq && dreq ? 3 - last : creq ? 1 : dreq ? 2 : 0;
      else begin
        mine = own == 1 ? creq : dreq;
        other = own == 1 ? dreq : creq;
        nxt = mine && !(other && run >= MAX) ? own : other ? 3 - own : 0;
      end
      if (nxt == 0) run = 0;
      else if (nxt == own) run++;
      else begin run = 1; last = nxt; end
      own = nxt;
    end
  endtask

  function automatic logic [1:0] rc();
    int v = $urandom_range(0, 19);
    return v < 6 ? 2'b00 : v < 12 ? 2'b01 : v < 19 ? 2'b10 : 2'b11;
  endfunction

  initial begin
    logic [1:0] cc, dc;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_gnt", 32'({cpu_gnt, dma_gnt}), 0);
    cyc(0, 2'b01, 9'h005, 0, 0, 0, 0);
    cyc(0, 2'b01, 9'h005, 0, 0, 0, 0);
    chk("lit_cpu_gnt", 32'(cpu_gnt), 1);
    chk("lit_cpu_cmd", 32'(mem_cmd), 1);
    chk("lit_cpu_addr", 32'(mem_addr), 32'h005);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_cpu_rvalid", 32'(cpu_rvalid), 1);
    cyc(0, 0, 0, 0, 2'b01, 9'h010, 0);
    cyc(0, 0, 0, 0, 2'b01, 9'h010, 0);
    chk("lit_dma_gnt", 32'(dma_gnt), 1);
    cyc(1, 0, 0, 0, 2'b01, 9'h010, 0);
    for (int i = 0; i < 17; i++) begin
      cyc(0, 2'b01, 9'(i), 0, 2'b01, 9'(i + 100), 0);
      if (i == 0) begin
        chk("lit_rst_gnt", 32'({cpu_gnt, dma_gnt}), 0);
        chk("lit_rst_drv", 32'(dma_rvalid), 0);
        chk("lit_rst_cmd", 32'(mem_cmd), 0);
      end
      if (i == 1) chk("lit_tie_cpu", 32'(cpu_gnt), 1);
      if (i == 4) chk("lit_burst_cpu", 32'(cpu_gnt), 1);
      if (i == 5) begin
        chk("lit_switch_dma", 32'(dma_gnt), 1);
        chk("lit_owed_crv", 32'(cpu_rvalid), 1);
        chk("lit_owed_drv", 32'(dma_rvalid), 0);
      end
      if (i == 9) chk("lit_back_cpu", 32'(cpu_gnt), 1);
      chk("one_gnt", 32'(cpu_gnt & dma_gnt), 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 2'b01, 9'h020, 0, 0, 0, 0);
    cyc(0, 2'b01, 9'h020, 0, 2'b10, 9'h1FF, 16'hBEEF);
    cyc(0, 0, 0, 0, 2'b10, 9'h1FF, 16'hBEEF);
    cyc(0, 0, 0, 0, 2'b10, 9'h1FF, 16'hBEEF);
    chk("lit_wr_gnt", 32'(dma_gnt), 1);
    chk("lit_wr_cmd", 32'(mem_cmd), 2);
    chk("lit_wr_addr", 32'(mem_addr), 32'h1FF);
    chk("lit_wr_data", 32'(mem_wdata), 32'hBEEF);
    cyc(0, 0, 0, 0, 2'b11, 9'h033, 16'h1234);
    chk("lit_ill_cmd", 32'(mem_cmd), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_err", 32'(cmd_err), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_err_sticky", 32'(cmd_err), 1);
    cc = 0; dc = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) cc = rc();
      if ($urandom_range(0, 9) < 3) dc = rc();
      cyc($urandom_range(0, 79) == 0, cc, 9'($urandom), 16'($urandom), dc, 9'($urandom), 16'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
